// File: rtl/ex_operand_stage.sv
// ID/EX operand register feeding the ALU: resolves operand sources, forwards
// from MEM/WB and interlocks on hazards. Optional feature macro: EX_FORWARD_EN.
`ifndef BITWIDTH
`define BITWIDTH 32
`endif

module ex_operand_stage #(
  parameter int WIDTH = `BITWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a FULL entry holds steady until consumed.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_use_imm,
  input  logic             in_use_pc,
  input  logic [3:0]       in_alu_op,
  input  logic [4:0]       in_rd_addr,
  input  logic             fwd_mem_we,
  input  logic             fwd_mem_is_load,
  input  logic [4:0]       fwd_mem_rd,
  input  logic [WIDTH-1:0] fwd_mem_data,
  input  logic             fwd_wb_we,
  input  logic [4:0]       fwd_wb_rd,
  input  logic [WIDTH-1:0] fwd_wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       out_rd_addr,
  output logic [WIDTH-1:0] out_store_data,
  output logic             dbg_state
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q;
  logic [4:0]       rd_addr_q;
  logic [WIDTH-1:0] store_q;
  logic [WIDTH-1:0] rs1_val, rs2_val;
  logic             mem_hit_rs1, mem_hit_rs2;
  logic             wb_hit_rs1, wb_hit_rs2;
  logic             hz;
  logic             capture;

  // Hit terms already exclude x0, so x0 can never pick up forwarded data.
  assign mem_hit_rs1 = fwd_mem_we && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == in_rs1_addr);
  assign mem_hit_rs2 = fwd_mem_we && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == in_rs2_addr);
  assign wb_hit_rs1  = fwd_wb_we  && (fwd_wb_rd  != 5'd0) && (fwd_wb_rd  == in_rs1_addr);
  assign wb_hit_rs2  = fwd_wb_we  && (fwd_wb_rd  != 5'd0) && (fwd_wb_rd  == in_rs2_addr);

`ifdef EX_FORWARD_EN
  always_comb begin
    rs1_val = in_rs1_data;
    if (mem_hit_rs1)     rs1_val = fwd_mem_data;
    else if (wb_hit_rs1) rs1_val = fwd_wb_data;
  end

  always_comb begin
    rs2_val = in_rs2_data;
    if (mem_hit_rs2)     rs2_val = fwd_mem_data;
    else if (wb_hit_rs2) rs2_val = fwd_wb_data;
  end

  // Only a load in MEM cannot be bypassed; its data arrives from WB next cycle.
  assign hz = fwd_mem_is_load && (mem_hit_rs1 || mem_hit_rs2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_data, fwd_wb_data, fwd_mem_is_load};

  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;

  // No bypass paths: wait until the register file itself holds the value.
  assign hz = mem_hit_rs1 || mem_hit_rs2 || wb_hit_rs1 || wb_hit_rs2;
`endif

  assign alu_a_d = in_use_pc  ? in_pc  : rs1_val;
  assign alu_b_d = in_use_imm ? in_imm : rs2_val;

  assign in_ready = ((state_q == ST_EMPTY) || out_ready) && !hz && !flush;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= 4'b0000;
      rd_addr_q <= 5'd0;
      store_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (capture) state_q <= ST_FULL;
        ST_FULL:  if (flush || (out_ready && !capture)) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
      if (capture) begin
        alu_a_q   <= alu_a_d;
        alu_b_q   <= alu_b_d;
        alu_op_q  <= in_alu_op;
        rd_addr_q <= in_rd_addr;
        store_q   <= rs2_val;
      end
    end
  end

  assign out_valid      = (state_q == ST_FULL);
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
  assign out_rd_addr    = rd_addr_q;
  assign out_store_data = store_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed hazard/stall/flush cases
// followed by random traffic; follows EX_FORWARD_EN like the design.
module tb_ex_operand_stage;
  localparam int W  = 32;
  localparam int EW = 3 * W + 9;

  logic          clk, rst_n, flush;
  logic          in_valid, in_ready;
  logic [4:0]    in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [W-1:0]  in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic          in_use_imm, in_use_pc;
  logic [3:0]    in_alu_op;
  logic          fwd_mem_we, fwd_mem_is_load, fwd_wb_we;
  logic [4:0]    fwd_mem_rd, fwd_wb_rd;
  logic [W-1:0]  fwd_mem_data, fwd_wb_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  alu_a, alu_b, out_store_data;
  logic [3:0]    alu_op;
  logic [4:0]    out_rd_addr;
  logic          dbg_state;

  logic [EW-1:0] exp_q[$];
  logic          m_full;
  int            n_checks, n_pass;

  ex_operand_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
    .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_is_load(fwd_mem_is_load),
    .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd_addr(out_rd_addr), .out_store_data(out_store_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // reference model
  function automatic logic [W-1:0] fwd_val(input logic [4:0] s, input logic [W-1:0] rf);
`ifdef EX_FORWARD_EN
    if (s != 0 && fwd_mem_we && fwd_mem_rd == s) return fwd_mem_data;
    if (s != 0 && fwd_wb_we && fwd_wb_rd == s) return fwd_wb_data;
`endif
    return rf;
  endfunction

  function automatic logic model_hz();
    logic m1, m2, w1, w2;
    m1 = fwd_mem_we && fwd_mem_rd != 0 && fwd_mem_rd == in_rs1_addr;
    m2 = fwd_mem_we && fwd_mem_rd != 0 && fwd_mem_rd == in_rs2_addr;
    w1 = fwd_wb_we && fwd_wb_rd != 0 && fwd_wb_rd == in_rs1_addr;
    w2 = fwd_wb_we && fwd_wb_rd != 0 && fwd_wb_rd == in_rs2_addr;
`ifdef EX_FORWARD_EN
    return fwd_mem_is_load && (m1 || m2);
`else
    return m1 || m2 || w1 || w2;
`endif
  endfunction

  task automatic idle_inputs();
    flush = 0; in_valid = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0;
    in_use_imm = 0; in_use_pc = 0; in_alu_op = 0;
    fwd_mem_we = 0; fwd_mem_is_load = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    out_ready = 1;
  endtask

  // One clock: check at the falling edge against the model, then advance.
  task automatic cycle();
    logic          exp_rdy;
    logic [EW-1:0] e;
    logic [W-1:0]  ea, eb, es;
    @(negedge clk);
    exp_rdy = (!m_full || out_ready) && !model_hz() && !flush;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_full);
    if (m_full) begin
      if (exp_q.size() == 0) begin
        check("queue_nonempty", 0, 1);
      end else begin
        e = exp_q[0];
        check("alu_a", alu_a, e[EW-1 -: W]);
        check("alu_b", alu_b, e[EW-1-W -: W]);
        check("alu_op", alu_op, e[W+8 -: 4]);
        check("rd_addr", out_rd_addr, e[W+4 -: 5]);
        check("store_data", out_store_data, e[W-1:0]);
        if (out_ready || flush) void'(exp_q.pop_front());
      end
    end
    if (in_valid && exp_rdy) begin
      ea = in_use_pc ? in_pc : fwd_val(in_rs1_addr, in_rs1_data);
      es = fwd_val(in_rs2_addr, in_rs2_data);
      eb = in_use_imm ? in_imm : es;
      exp_q.push_back({ea, eb, in_alu_op, in_rd_addr, es});
      m_full = 1'b1;
    end else if (flush || out_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [W-1:0] d1, input logic [W-1:0] d2,
                             input logic [W-1:0] imm, input logic ui,
                             input logic [3:0] op, input logic [4:0] rd);
    in_valid = 1; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = ui;
    in_alu_op = op; in_rd_addr = rd; in_pc = 32'h1000 + {27'd0, rd, 2'b00};
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_full = 0;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rd", out_rd_addr, 0);
    check("rst_store", out_store_data, 0);
    @(posedge clk); #1;

    // basic immediate capture
    drive_instr(5'd1, 5'd2, 32'd5, 32'd9, 32'd7, 1'b1, 4'b0000, 5'd10);
    cycle();
    idle_inputs();
    check("basic_valid", out_valid, 1);
    check("basic_a", alu_a, 32'd5);
    check("basic_b", alu_b, 32'd7);
    check("basic_op", alu_op, 4'b0000);
    cycle();

    // MEM vs WB forwarding on rs1, then the x0 case
    drive_instr(5'd3, 5'd0, 32'h11, 32'h22, 32'h0, 1'b0, 4'b0010, 5'd5);
    fwd_mem_we = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'h100;
    fwd_wb_we = 1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h200;
    cycle();
    fwd_mem_we = 0; fwd_wb_we = 0;
    cycle();
    drive_instr(5'd0, 5'd0, 32'h33, 32'h44, 32'h0, 1'b0, 4'b0011, 5'd6);
    fwd_mem_we = 1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h100;
    fwd_wb_we = 1; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h200;
    cycle();
    idle_inputs();
    cycle();

    // load-use on rs2, then the load sits in WB
    drive_instr(5'd1, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 4'b0100, 5'd7);
    fwd_mem_we = 1; fwd_mem_is_load = 1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h999;
    cycle();
    fwd_mem_we = 0; fwd_mem_is_load = 0;
    fwd_wb_we = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hABC;
    cycle();
    fwd_wb_we = 0;
    cycle();
    idle_inputs();
    cycle();

    // back-pressure for three cycles, then consume+capture together
    drive_instr(5'd2, 5'd3, 32'hA, 32'hB, 32'h0, 1'b0, 4'b0101, 5'd8);
    cycle();
    out_ready = 0;
    drive_instr(5'd5, 5'd6, 32'hC, 32'hD, 32'hE, 1'b1, 4'b0110, 5'd9);
    repeat (3) cycle();
    out_ready = 1;
    cycle();
    check("no_bubble", out_valid, 1);
    check("no_bubble_a", alu_a, 32'hC);

    // flush with in_valid while FULL
    drive_instr(5'd7, 5'd1, 32'hF0, 32'hF1, 32'h0, 1'b0, 4'b0111, 5'd11);
    out_ready = 0; flush = 1;
    cycle();
    flush = 0; in_valid = 0; out_ready = 1;
    check("flush_empty", out_valid, 0);
    cycle();

    // WB RAW match on rs1 held for a few cycles
    drive_instr(5'd6, 5'd0, 32'h66, 32'h0, 32'h1, 1'b1, 4'b1000, 5'd12);
    fwd_wb_we = 1; fwd_wb_rd = 5'd6; fwd_wb_data = 32'h600;
    repeat (3) cycle();
    fwd_wb_we = 0;
    cycle();
    idle_inputs();
    cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      in_rs1_addr     = 5'($urandom_range(0, 7));
      in_rs2_addr     = 5'($urandom_range(0, 7));
      in_rs1_data     = $urandom;
      in_rs2_data     = $urandom;
      in_imm          = $urandom;
      in_pc           = $urandom;
      in_use_imm      = 1'($urandom_range(0, 1));
      in_use_pc       = 1'($urandom_range(0, 1));
      in_alu_op       = 4'($urandom_range(0, 15));
      in_rd_addr      = 5'($urandom_range(0, 31));
      fwd_mem_we      = ($urandom_range(0, 2) == 0);
      fwd_mem_is_load = 1'($urandom_range(0, 1));
      fwd_mem_rd      = 5'($urandom_range(0, 7));
      fwd_mem_data    = $urandom;
      fwd_wb_we       = ($urandom_range(0, 2) == 0);
      fwd_wb_rd       = 5'($urandom_range(0, 7));
      fwd_wb_data     = $urandom;
      out_ready       = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // reset while stalled discards the entry
    idle_inputs();
    drive_instr(5'd1, 5'd2, 32'h77, 32'h88, 32'h0, 1'b0, 4'b1111, 5'd31);
    out_ready = 0;
    repeat (2) cycle();
    rst_n = 0;
    #2;
    check("midrst_valid", out_valid, 0);
    check("midrst_a", alu_a, 0);
    exp_q.delete();
    m_full = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
